// File: rtl/qspi_psram_multi_model.sv
// QSPI PSRAM behavioural model with byte-wide internal memory.
// Supports SPI/QPI commands, quad and serial read/write, page-wrapped bursts and a guarded reset.
module qspi_psram_multi_model #(
  parameter int unsigned ADR_BITS  = 16,
  parameter int unsigned RD_WAIT   = 6,
  parameter int unsigned PAGE_BITS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe,
  output logic       qpi_mode,
  output logic       cmd_err
);

  localparam int unsigned DEPTH = 2 ** ADR_BITS;
  localparam int unsigned CNT_W = 8;
  localparam logic [ADR_BITS-1:0] PAGE_MASK =
    (PAGE_BITS == 0 || PAGE_BITS >= ADR_BITS) ? {ADR_BITS{1'b1}}
                                              : ADR_BITS'((64'd1 << PAGE_BITS) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADR, S_WAIT, S_WDAT, S_RDAT, S_SINK
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_sck_s;
  logic                r_ce_n_s;
  logic [3:0]          r_sio_s;
  logic [CNT_W-1:0]    r_cnt;
  logic [6:0]          r_cmd;
  logic                r_quad;
  logic                r_is_rd;
  logic [ADR_BITS-1:0] r_adr;
  logic [6:0]          r_byte;
  logic                r_qpi;
  logic                r_rst_armed;
  logic                r_cmd_err;
  logic [3:0]          r_sio_o;
  logic [7:0]          r_mem [DEPTH];

  logic                w_rise;
  logic                w_fall;
  logic [7:0]          w_cmd_nxt;
  logic                w_cmd_last;
  logic                w_quad_cmd;
  logic                w_ser_cmd;
  logic                w_cmd_go;
  logic                w_known;
  logic                w_bad;
  logic                w_adr_last;
  logic                w_wait_last;
  logic                w_unit_last;
  logic [7:0]          w_byte_nxt;
  logic [7:0]          w_rd_byte;
  logic [2:0]          w_bit_idx;
  logic                w_sio_oe;
  logic                w_mem_we;
  logic [7:0]          w_mem_wdat;

  function automatic logic [ADR_BITS-1:0] adr_inc(input logic [ADR_BITS-1:0] a);
    return (a & ~PAGE_MASK) | ((a + ADR_BITS'(1)) & PAGE_MASK);
  endfunction

  // One clk synchroniser on the controller-side pins
  always_ff @(posedge clk) begin
    r_sck_s  <= sck;
    r_ce_n_s <= ce_n;
    r_sio_s  <= sio_i;
  end

  assign w_rise = sck & ~r_sck_s;
  assign w_fall = ~sck & r_sck_s;

  assign w_cmd_nxt   = r_qpi ? {r_cmd[3:0], r_sio_s} : {r_cmd, r_sio_s[0]};
  assign w_cmd_last  = (r_cnt == (r_qpi ? CNT_W'(1) : CNT_W'(7)));
  assign w_quad_cmd  = (w_cmd_nxt == 8'hEB) || (w_cmd_nxt == 8'h38);
  assign w_ser_cmd   = (w_cmd_nxt == 8'h03) || (w_cmd_nxt == 8'h02);
  assign w_cmd_go    = w_quad_cmd || (w_ser_cmd && !r_qpi);
  assign w_known     = w_quad_cmd || w_ser_cmd || (w_cmd_nxt == 8'h35) ||
                       (w_cmd_nxt == 8'hF5) || (w_cmd_nxt == 8'h66) || (w_cmd_nxt == 8'h99);
  assign w_bad       = !w_known || (w_ser_cmd && r_qpi);
  assign w_adr_last  = (r_cnt == (r_quad ? CNT_W'(5) : CNT_W'(23)));
  assign w_wait_last = (r_cnt == CNT_W'(RD_WAIT - 1));
  assign w_unit_last = (r_cnt == (r_quad ? CNT_W'(1) : CNT_W'(7)));
  assign w_byte_nxt  = r_quad ? {r_byte[3:0], r_sio_s} : {r_byte, r_sio_s[0]};
  assign w_rd_byte   = r_mem[r_adr];
  assign w_bit_idx   = 3'd7 - r_cnt[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_ce_n_s) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next_state = S_CMD;
        S_CMD:  if (w_rise && w_cmd_last) w_next_state = w_cmd_go ? S_ADR : S_SINK;
        S_ADR:  if (w_rise && w_adr_last)
                  w_next_state = !r_is_rd ? S_WDAT :
                                 (r_quad && RD_WAIT != 0) ? S_WAIT : S_RDAT;
        S_WAIT: if (w_rise && w_wait_last) w_next_state = S_RDAT;
        default: w_next_state = r_state;
      endcase
    end
  end

  // Abort by CE takes priority over a coincident data edge
  always_comb begin
    w_sio_oe   = (r_state == S_RDAT) && !r_ce_n_s;
    w_mem_we   = 1'b0;
    w_mem_wdat = w_byte_nxt;
    if (r_state == S_WDAT && w_rise && !r_ce_n_s && w_unit_last) w_mem_we = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_quad      <= 1'b0;
      r_is_rd     <= 1'b0;
      r_adr       <= '0;
      r_byte      <= '0;
      r_qpi       <= 1'b0;
      r_rst_armed <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_sio_o     <= '0;
    end else begin
      r_cmd_err <= 1'b0;
      if (r_ce_n_s) begin
        r_cnt   <= '0;
        r_sio_o <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_cnt <= '0;
          S_CMD: if (w_rise) begin
            r_cmd <= w_cmd_nxt[6:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_cmd_last) begin
              r_cnt       <= '0;
              r_adr       <= '0;
              r_quad      <= w_quad_cmd;
              r_is_rd     <= (w_cmd_nxt == 8'hEB) || (w_cmd_nxt == 8'h03);
              r_rst_armed <= (w_cmd_nxt == 8'h66);
              r_cmd_err   <= w_bad;
              if (w_cmd_nxt == 8'h35) r_qpi <= 1'b1;
              if (w_cmd_nxt == 8'hF5 || (w_cmd_nxt == 8'h99 && r_rst_armed)) r_qpi <= 1'b0;
            end
          end
          S_ADR: if (w_rise) begin
            r_adr <= r_quad ? ADR_BITS'({r_adr, r_sio_s}) : ADR_BITS'({r_adr, r_sio_s[0]});
            r_cnt <= w_adr_last ? '0 : r_cnt + CNT_W'(1);
          end
          S_WAIT: if (w_rise) r_cnt <= w_wait_last ? '0 : r_cnt + CNT_W'(1);
          S_WDAT: if (w_rise) begin
            r_byte <= w_byte_nxt[6:0];
            r_cnt  <= w_unit_last ? '0 : r_cnt + CNT_W'(1);
            if (w_unit_last) r_adr <= adr_inc(r_adr);
          end
          S_RDAT: if (w_fall) begin
            r_sio_o <= r_quad ? (r_cnt[0] ? w_rd_byte[3:0] : w_rd_byte[7:4])
                              : {2'b00, w_rd_byte[w_bit_idx], 1'b0};
            r_cnt   <= w_unit_last ? '0 : r_cnt + CNT_W'(1);
            if (w_unit_last) r_adr <= adr_inc(r_adr);
          end
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Memory survives reset
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) r_mem[r_adr] <= w_mem_wdat;
  end

  assign sio_o    = r_sio_o;
  assign sio_oe   = w_sio_oe;
  assign qpi_mode = r_qpi;
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_qspi_psram_multi_model.sv
// Directed bench for qspi_psram_multi_model: default build plus a RD_WAIT=0 / ADR_BITS=12 build.
module tb_qspi_psram_multi_model;

  logic       clk;
  logic       rst_n;
  logic       sck;
  logic       ce_n0;
  logic       ce_n1;
  logic [3:0] sio_i;
  logic [3:0] sio_o0, sio_o1;
  logic       sio_oe0, sio_oe1;
  logic       qpi0, qpi1;
  logic       err0, err1;

  int         errors;
  int         checks;
  int         err_cnt0;
  int         err_cnt1;
  logic       sel;
  logic [3:0] last_o;
  logic       last_oe;

  qspi_psram_multi_model dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ce_n(ce_n0), .sio_i(sio_i),
    .sio_o(sio_o0), .sio_oe(sio_oe0), .qpi_mode(qpi0), .cmd_err(err0)
  );

  qspi_psram_multi_model #(.ADR_BITS(12), .RD_WAIT(0), .PAGE_BITS(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .ce_n(ce_n1), .sio_i(sio_i),
    .sio_o(sio_o1), .sio_oe(sio_oe1), .qpi_mode(qpi1), .cmd_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err0) err_cnt0 = err_cnt0 + 1;
    if (err1) err_cnt1 = err_cnt1 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // One sck period; captures the selected DUT's outputs after the falling edge
  task automatic pulse(input logic [3:0] d);
    sio_i = d;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (3) @(negedge clk);
    last_o  = sel ? sio_o1 : sio_o0;
    last_oe = sel ? sio_oe1 : sio_oe0;
  endtask

  task automatic ce_lo();
    if (sel) ce_n1 = 1'b0;
    else     ce_n0 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ce_hi();
    ce_n0 = 1'b1;
    ce_n1 = 1'b1;
    sio_i = 4'h0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] c, input logic q);
    if (q) begin
      pulse(c[7:4]);
      pulse(c[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) pulse({3'b000, c[i]});
    end
  endtask

  task automatic one_cmd(input logic [7:0] c, input logic q);
    ce_lo();
    cmd(c, q);
    ce_hi();
  endtask

  task automatic adr_q(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4]);
  endtask

  task automatic adr_s(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) pulse({3'b000, a[i]});
  endtask

  task automatic wr_q(input logic [7:0] b);
    pulse(b[7:4]);
    pulse(b[3:0]);
  endtask

  task automatic wr_s(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]});
  endtask

  task automatic dummy(input int n);
    for (int i = 0; i < n; i++) pulse(4'h0);
  endtask

  task automatic rd_quad(input logic q, input logic [23:0] a, input int nw, input int nb,
                         output logic [31:0] d, output logic oe);
    ce_lo();
    cmd(8'hEB, q);
    adr_q(a);
    dummy(nw);
    oe = last_oe;
    d  = '0;
    for (int k = 0; k < nb * 2; k++) begin
      if (k != 0) pulse(4'h0);
      d = {d[27:0], last_o};
    end
    ce_hi();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sck = 1'b0; ce_n0 = 1'b1; ce_n1 = 1'b1; sio_i = 4'h0; sel = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sio_oe0 !== 1'b0) begin errors++; $display("FAIL reset_oe0: got %b exp 0", sio_oe0); end
    checks++; if (sio_o0 !== 4'h0) begin errors++; $display("FAIL reset_o0: got %h exp 0", sio_o0); end
    checks++; if (qpi0 !== 1'b0) begin errors++; $display("FAIL reset_qpi0: got %b exp 0", qpi0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0: got %b exp 0", err0); end
    checks++; if (sio_oe1 !== 1'b0) begin errors++; $display("FAIL reset_oe1: got %b exp 0", sio_oe1); end
    checks++; if (qpi1 !== 1'b0) begin errors++; $display("FAIL reset_qpi1: got %b exp 0", qpi1); end
  endtask

  task automatic test_quad_rw();
    logic [15:0] d;
    logic [31:0] r;
    logic        oe;
    sel = 1'b0;
    ce_lo(); cmd(8'h38, 1'b0); adr_q(24'h000010); wr_q(8'hA5); wr_q(8'h3C); ce_hi();
    ce_lo(); cmd(8'hEB, 1'b0); adr_q(24'h000010);
    checks++; if (last_oe !== 1'b0) begin errors++; $display("FAIL oe_in_adr: got %b exp 0", last_oe); end
    dummy(5);
    checks++; if (last_oe !== 1'b0) begin errors++; $display("FAIL oe_in_wait: got %b exp 0", last_oe); end
    dummy(1);
    checks++; if (last_oe !== 1'b1) begin errors++; $display("FAIL oe_in_rdat: got %b exp 1", last_oe); end
    d = {12'h000, last_o};
    for (int k = 0; k < 3; k++) begin pulse(4'h0); d = {d[11:0], last_o}; end
    checks++; if (d !== 16'hA53C) begin errors++; $display("FAIL quad_rd: got %h exp a53c", d); end
    ce_hi();
    checks++; if (sio_oe0 !== 1'b0) begin errors++; $display("FAIL oe_after_ce: got %b exp 0", sio_oe0); end
    rd_quad(1'b0, 24'h120010, 6, 1, r, oe);
    checks++; if (r[7:0] !== 8'hA5) begin errors++; $display("FAIL adr_upper_ignored: got %h exp a5", r[7:0]); end
  endtask

  task automatic test_spi_wrap();
    logic [15:0] d;
    logic [3:0]  other;
    logic [31:0] r;
    logic        oe;
    sel = 1'b0;
    ce_lo(); cmd(8'h02, 1'b0); adr_s(24'h0003FF); wr_s(8'h11); wr_s(8'h22); ce_hi();
    ce_lo(); cmd(8'h03, 1'b0); adr_s(24'h0003FF);
    checks++; if (last_oe !== 1'b1) begin errors++; $display("FAIL spi_rd_oe: got %b exp 1", last_oe); end
    d = {15'h0000, last_o[1]};
    other = last_o & 4'b1101;
    for (int k = 0; k < 15; k++) begin
      pulse(4'h0);
      d = {d[14:0], last_o[1]};
      other = other | (last_o & 4'b1101);
    end
    ce_hi();
    checks++; if (d !== 16'h1122) begin errors++; $display("FAIL spi_rd_wrap: got %h exp 1122", d); end
    checks++; if (other !== 4'h0) begin errors++; $display("FAIL spi_rd_idle_bits: got %h exp 0", other); end
    rd_quad(1'b0, 24'h000000, 6, 1, r, oe);
    checks++; if (r[7:0] !== 8'h22) begin errors++; $display("FAIL wrap_to_zero: got %h exp 22", r[7:0]); end
    ce_lo(); cmd(8'h38, 1'b0); adr_q(24'h0007FF); wr_q(8'h5A); wr_q(8'h6B); ce_hi();
    rd_quad(1'b0, 24'h000400, 6, 1, r, oe);
    checks++; if (r[7:0] !== 8'h6B) begin errors++; $display("FAIL page_upper_hold: got %h exp 6b", r[7:0]); end
  endtask

  task automatic test_qpi();
    int          e0;
    logic [31:0] r;
    logic        oe;
    sel = 1'b0;
    e0 = err_cnt0;
    one_cmd(8'h35, 1'b0);
    checks++; if (qpi0 !== 1'b1) begin errors++; $display("FAIL qpi_enter: got %b exp 1", qpi0); end
    rd_quad(1'b1, 24'h000010, 6, 2, r, oe);
    checks++; if (r[15:0] !== 16'hA53C) begin errors++; $display("FAIL qpi_rd: got %h exp a53c", r[15:0]); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL qpi_rd_oe: got %b exp 1", oe); end
    ce_lo(); cmd(8'h03, 1'b1);
    checks++; if (err_cnt0 !== e0 + 1) begin errors++; $display("FAIL qpi_bad_err: got %0d exp %0d", err_cnt0, e0 + 1); end
    dummy(4);
    checks++; if (last_oe !== 1'b0) begin errors++; $display("FAIL qpi_bad_oe: got %b exp 0", last_oe); end
    ce_hi();
    checks++; if (qpi0 !== 1'b1) begin errors++; $display("FAIL qpi_kept: got %b exp 1", qpi0); end
    one_cmd(8'hF5, 1'b1);
    checks++; if (qpi0 !== 1'b0) begin errors++; $display("FAIL qpi_exit: got %b exp 0", qpi0); end
    checks++; if (err_cnt0 !== e0 + 1) begin errors++; $display("FAIL qpi_err_total: got %0d exp %0d", err_cnt0, e0 + 1); end
  endtask

  task automatic test_reset_seq();
    int e0;
    sel = 1'b0;
    one_cmd(8'h35, 1'b0);
    one_cmd(8'h99, 1'b1);
    checks++; if (qpi0 !== 1'b1) begin errors++; $display("FAIL rst_unarmed: got %b exp 1", qpi0); end
    one_cmd(8'h66, 1'b1);
    one_cmd(8'h99, 1'b1);
    checks++; if (qpi0 !== 1'b0) begin errors++; $display("FAIL rst_armed: got %b exp 0", qpi0); end
    e0 = err_cnt0;
    one_cmd(8'h35, 1'b0);
    one_cmd(8'h66, 1'b1);
    one_cmd(8'h05, 1'b1);
    one_cmd(8'h99, 1'b1);
    checks++; if (qpi0 !== 1'b1) begin errors++; $display("FAIL rst_disarmed: got %b exp 1", qpi0); end
    checks++; if (err_cnt0 !== e0 + 1) begin errors++; $display("FAIL unknown_err: got %0d exp %0d", err_cnt0, e0 + 1); end
    one_cmd(8'hF5, 1'b1);
    checks++; if (qpi0 !== 1'b0) begin errors++; $display("FAIL rst_seq_exit: got %b exp 0", qpi0); end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    logic        oe;
    sel = 1'b0;
    ce_lo(); cmd(8'h38, 1'b0); adr_q(24'h000102); wr_q(8'h77); ce_hi();
    ce_lo(); cmd(8'h38, 1'b0); adr_q(24'h000100); wr_q(8'h01); wr_q(8'h02); pulse(4'hF);
    // Low nibble rise lands on the same clk as the synchronised CE deassert
    sio_i = 4'h8;
    repeat (2) @(negedge clk);
    ce_n0 = 1'b1;
    @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (3) @(negedge clk);
    ce_hi();
    rd_quad(1'b0, 24'h000100, 6, 3, r, oe);
    checks++; if (r[23:0] !== 24'h010277) begin errors++; $display("FAIL abort_partial: got %h exp 010277", r[23:0]); end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0]  b;
    logic [31:0] r;
    logic        oe;
    sel = 1'b1;
    ce_lo(); cmd(8'h38, 1'b0); adr_q(24'h001200); wr_q(8'h9C); wr_q(8'hD4); ce_hi();
    ce_lo(); cmd(8'hEB, 1'b0); adr_q(24'h001200);
    checks++; if (last_oe !== 1'b1) begin errors++; $display("FAIL nowait_oe: got %b exp 1", last_oe); end
    b[7:4] = last_o;
    pulse(4'h0);
    b[3:0] = last_o;
    checks++; if (b !== 8'h9C) begin errors++; $display("FAIL nowait_rd: got %h exp 9c", b); end
    pulse(4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (sio_oe1 !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b exp 0", sio_oe1); end
    checks++; if (sio_o1 !== 4'h0) begin errors++; $display("FAIL rst_mid_o: got %h exp 0", sio_o1); end
    @(negedge clk);
    checks++; if (sio_oe1 !== 1'b0) begin errors++; $display("FAIL rst_mid_oe_hold: got %b exp 0", sio_oe1); end
    ce_hi();
    rd_quad(1'b0, 24'h000201, 0, 1, r, oe);
    checks++; if (r[7:0] !== 8'hD4) begin errors++; $display("FAIL rst_fresh_rd: got %h exp d4", r[7:0]); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rst_fresh_oe: got %b exp 1", oe); end
    checks++; if (err_cnt1 !== 0) begin errors++; $display("FAIL dut1_err: got %0d exp 0", err_cnt1); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    err_cnt0 = 0;
    err_cnt1 = 0;
    last_o = 4'h0;
    last_oe = 1'b0;
    test_reset();
    test_quad_rw();
    test_spi_wrap();
    test_qpi();
    test_reset_seq();
    test_abort();
    test_rst_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
